md_sequencer: RTL and testbench

Iterative multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO register pair and executes MULT, MULTU, DIV and DIVU over a fixed number of cycles. It sits beside the EX stage and raises a stall request to the hazard unit while a later instruction needs HI/LO or the unit. MFHI/MFLO read HI/LO directly; MTHI/MTLO write them.

---
 rtl/md_if.sv | 28 ++
 rtl/md_sequencer.sv | 178 +++++++++++++++++
 tb/tb_md_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// Handshake and result bundle between the EX stage / hazard unit and the
// multiply/divide sequencer.
interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             mthi;
    logic             mtlo;
    logic             use_hilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall_md;

    modport master (
        output start, op, srca, srcb, mthi, mtlo, use_hilo,
        input  hi, lo, busy, done, stall_md
    );

    modport slave (
        input  start, op, srca, srcb, mthi, mtlo, use_hilo,
        output hi, lo, busy, done, stall_md
    );
endinterface

// File: rtl/md_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    md_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     sub_s;
    logic               ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mag_srca_s;
    logic [WIDTH-1:0]   mag_srcb_s;
    logic               unused_s;

    // Next-state, datapath iteration and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        mag_srca_s = (bus.op[0] && bus.srca[WIDTH-1]) ? neg_w(bus.srca) : bus.srca;
        mag_srcb_s = (bus.op[0] && bus.srcb[WIDTH-1]) ? neg_w(bus.srcb) : bus.srcb;

        mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
        rem_sh_s  = {acc_q[2*WIDTH-1:WIDTH], b_q[WIDTH-1]};
        ge_s      = (rem_sh_s >= {1'b0, a_q});
        sub_s     = rem_sh_s - {1'b0, a_q};
        prod_s    = (sa_q ^ sb_q) ? neg_2w(acc_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    sa_d    = bus.op[0] & bus.srca[WIDTH-1];
                    sb_d    = bus.op[0] & bus.srcb[WIDTH-1];
                    dz_d    = bus.op[1] & (bus.srcb == {WIDTH{1'b0}});
                    // Divide keeps divisor in a_q and shifts the dividend out of b_q.
                    a_d     = bus.op[1] ? mag_srcb_s : mag_srca_s;
                    b_d     = bus.op[1] ? mag_srca_s : mag_srcb_s;
                    acc_d   = {(2*WIDTH){1'b0}};
                    count_d = {CW{1'b0}};
                    state_d = CALC;
                    busy_d  = 1'b1;
                end else begin
                    if (bus.mthi) begin
                        hi_d = bus.srca;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.mtlo) begin
                        lo_d = bus.srca;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    acc_d[2*WIDTH-1:WIDTH] = ge_s ? sub_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
                    acc_d[WIDTH-1:0]       = {acc_q[WIDTH-2:0], ge_s};
                    b_d                    = {b_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                if (op_q[1]) begin
                    // Divide by zero keeps the all-ones quotient regardless of signs.
                    lo_d = ((sa_q ^ sb_q) && !dz_q) ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                    hi_d = sa_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign unused_s = sub_s[WIDTH];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= {CW{1'b0}};
            op_q    <= 2'b00;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.stall_md = busy_q & (bus.use_hilo | bus.start);
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: hand-computed MULT/DIV results, cycle-exact
// busy/done timing, stall behaviour, MTHI/MTLO handling and mid-operation reset.
module tb_md_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_if #(.WIDTH(32)) bus ();

    md_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic with_mtlo, input logic with_stall);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.srca     = a;
        bus.srcb     = b;
        bus.mtlo     = with_mtlo;
        bus.use_hilo = with_stall;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        chk("busy_e0", {31'd0, bus.busy}, 32'd1);
        chk("done_e0", {31'd0, bus.done}, 32'd0);
        chk("lo_hold_e0", bus.lo, m_lo);
        for (int e = 1; e <= 32; e++) begin
            if (with_stall && e == 5) begin
                bus.mthi = 1'b1;
                bus.srca = 32'hAAAA0000;
            end
            @(posedge clk); #1;
            bus.mthi = 1'b0;
            chk("busy_calc", {31'd0, bus.busy}, 32'd1);
            if (with_stall) begin
                chk("stall_calc", {31'd0, bus.stall_md}, 32'd1);
            end
        end
        @(posedge clk); #1;
        chk("busy_e33", {31'd0, bus.busy}, 32'd0);
        chk("done_e33", {31'd0, bus.done}, 32'd1);
        chk("stall_e33", {31'd0, bus.stall_md}, 32'd0);
        chk("hi_e33", bus.hi, eh);
        chk("lo_e33", bus.lo, el);
        m_hi = eh;
        m_lo = el;
        bus.use_hilo = 1'b0;
        @(posedge clk); #1;
        chk("done_e34", {31'd0, bus.done}, 32'd0);
        chk("hi_hold_e34", bus.hi, eh);
    endtask

    initial begin
        n_checks     = 0;
        n_err        = 0;
        m_hi         = 32'd0;
        m_lo         = 32'd0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.srca     = 32'd0;
        bus.srcb     = 32'd0;
        bus.mthi     = 1'b0;
        bus.mtlo     = 1'b0;
        bus.use_hilo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
        run_op(2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op(2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);

        // Stall asserted throughout; mthi injected mid-operation must be ignored.
        run_op(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b1);

        @(negedge clk);
        bus.mthi = 1'b1;
        bus.srca = 32'hAAAA0000;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        chk("mthi_idle_hi", bus.hi, 32'hAAAA0000);
        chk("mthi_idle_lo", bus.lo, m_lo);
        chk("mthi_idle_done", {31'd0, bus.done}, 32'd0);
        chk("mthi_idle_busy", {31'd0, bus.busy}, 32'd0);
        m_hi = 32'hAAAA0000;

        // start has priority over a simultaneous mtlo.
        run_op(2'b00, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, 32'hFFFFFFFD, 1'b1, 1'b0);

        // Reset in the middle of CALC aborts without writing a result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.srca  = 32'hFFFFFFFF;
        bus.srcb  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
